// File: rtl/data_lane_rx_pkg.sv
// Shared types and constants for the data lane receiver: lane states, LP line codes,
// the HS sync byte and small match helpers used by the aligner.
package data_lane_rx_pkg;

    typedef enum logic [2:0] {
        STOP_WAIT = 3'd0,
        LP11      = 3'd1,
        LP01      = 3'd2,
        LP00      = 3'd3,
        HS_SYNC   = 3'd4,
        HS_DATA   = 3'd5
    } lane_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    // LP codes are {lp_p, lp_n}
    localparam logic [1:0] LP_11 = 2'b11;
    localparam logic [1:0] LP_01 = 2'b01;
    localparam logic [1:0] LP_00 = 2'b00;
    localparam logic [1:0] LP_10 = 2'b10;

    function automatic logic [2:0] lowest_index(input logic [7:0] vec);
        logic [2:0] idx;
        casez (vec)
            8'b???????1: idx = 3'd0;
            8'b??????10: idx = 3'd1;
            8'b?????100: idx = 3'd2;
            8'b????1000: idx = 3'd3;
            8'b???10000: idx = 3'd4;
            8'b??100000: idx = 3'd5;
            8'b?1000000: idx = 3'd6;
            8'b10000000: idx = 3'd7;
            default:     idx = 3'd0;
        endcase
        return idx;
    endfunction

    function automatic logic one_bit_off(input logic [7:0] slice);
        logic [7:0] diff;
        diff = slice ^ SYNC_BYTE;
        return (diff != 8'h00) && ((diff & (diff - 8'h01)) == 8'h00);
    endfunction

endpackage

// File: rtl/data_rx_align.sv
// Byte aligner: 16-bit sliding window, sync-byte offset search and aligned-byte mux.
// DATA_LANE_RX_SOT_TOLERANT_EN additionally accepts a one-bit-error sync byte.
module data_rx_align
    import data_lane_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_rx_byte,
    input  logic       i_latch,
    output logic       o_match,
    output logic [7:0] o_aligned
);

    logic [7:0]  r_prev;
    logic [2:0]  r_k;
    logic [15:0] w_window;
    logic [7:0]  w_exact_vec;
    logic        w_match;
    logic [2:0]  w_k_sel;
`ifdef DATA_LANE_RX_SOT_TOLERANT_EN
    logic [7:0]  w_tol_vec;
`endif

    assign w_window = {i_rx_byte, r_prev};

    // Offset search; the lowest matching offset wins, exact matches beat tolerant ones.
    always_comb begin
        w_exact_vec = 8'h00;
`ifdef DATA_LANE_RX_SOT_TOLERANT_EN
        w_tol_vec   = 8'h00;
`endif
        for (int k = 0; k < 8; k++) begin
            w_exact_vec[k] = (w_window[k +: 8] == SYNC_BYTE);
`ifdef DATA_LANE_RX_SOT_TOLERANT_EN
            w_tol_vec[k]   = one_bit_off(w_window[k +: 8]);
`endif
        end
`ifdef DATA_LANE_RX_SOT_TOLERANT_EN
        w_match = (|w_exact_vec) | (|w_tol_vec);
        if (|w_exact_vec) begin
            w_k_sel = lowest_index(w_exact_vec);
        end else begin
            w_k_sel = lowest_index(w_tol_vec);
        end
`else
        w_match = |w_exact_vec;
        w_k_sel = lowest_index(w_exact_vec);
`endif
    end

    // Previous-byte history and latched alignment offset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 8'h00;
            r_k    <= 3'd0;
        end else begin
            r_prev <= i_rx_byte;
            if (i_latch) begin
                r_k <= w_k_sel;
            end
        end
    end

    assign o_match   = w_match;
    assign o_aligned = w_window[r_k +: 8];

endmodule

// File: rtl/data_lane_rx.sv
// Data lane receiver: LP line-state sequencing into HS, sync search, aligned payload out.
// Build option DATA_LANE_RX_SOT_TOLERANT_EN: sync search tolerates one bit error.
module data_lane_rx
    import data_lane_rx_pkg::*;
#(
    parameter int TD_SETTLE    = 4,
    parameter int SYNC_TIMEOUT = 16
)(
    input  logic       byte_clk,
    input  logic       byte_rst,
    input  logic       lp_p,
    input  logic       lp_n,
    input  logic [7:0] rx_byte,
    output logic [7:0] data,
    output logic       valid,
    output logic       sot,
    output logic       eot,
    output logic       err_sot,
    output logic       err_ctrl,
    output logic       hs_term_en,
    output logic       lane_idle
);

    localparam logic [3:0] SETTLE_LAST = 4'(TD_SETTLE - 1);
    localparam logic [7:0] SYNC_LAST   = 8'(SYNC_TIMEOUT - 1);

    lane_state_e r_state;
    lane_state_e w_next_state;
    logic [1:0]  r_lp_meta;
    logic [1:0]  r_lp_sync;
    logic [1:0]  w_lp;
    logic [3:0]  r_settle_cnt;
    logic [3:0]  w_settle_cnt;
    logic [7:0]  r_sync_cnt;
    logic [7:0]  w_sync_cnt;
    logic        w_match;
    logic        w_latch;
    logic [7:0]  w_aligned;
    logic [7:0]  w_data;
    logic        w_valid;
    logic        w_sot;
    logic        w_eot;
    logic        w_err_sot;
    logic        w_err_ctrl;
    logic        w_hs_term_en;
    logic        w_lane_idle;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_sot;
    logic        r_eot;
    logic        r_err_sot;
    logic        r_err_ctrl;
    logic        r_hs_term_en;
    logic        r_lane_idle;

    data_rx_align u_align (
        .clk       (byte_clk),
        .rst       (byte_rst),
        .i_rx_byte (rx_byte),
        .i_latch   (w_latch),
        .o_match   (w_match),
        .o_aligned (w_aligned)
    );

    // Two-flop synchronizer for the asynchronous LP receiver outputs.
    always_ff @(posedge byte_clk or posedge byte_rst) begin
        if (byte_rst) begin
            r_lp_meta <= 2'b00;
            r_lp_sync <= 2'b00;
        end else begin
            r_lp_meta <= {lp_p, lp_n};
            r_lp_sync <= r_lp_meta;
        end
    end

    assign w_lp = r_lp_sync;

    // Next-state, counter and output-pulse decode.
    always_comb begin
        w_next_state = r_state;
        w_settle_cnt = r_settle_cnt;
        w_sync_cnt   = r_sync_cnt;
        w_data       = 8'h00;
        w_valid      = 1'b0;
        w_sot        = 1'b0;
        w_eot        = 1'b0;
        w_err_sot    = 1'b0;
        w_err_ctrl   = 1'b0;
        case (r_state)
            STOP_WAIT: begin
                if (w_lp == LP_11) begin
                    w_next_state = LP11;
                end else begin
                    w_next_state = STOP_WAIT;
                end
            end
            LP11: begin
                case (w_lp)
                    LP_11:   w_next_state = LP11;
                    LP_01:   w_next_state = LP01;
                    default: begin
                        w_next_state = STOP_WAIT;
                        w_err_ctrl   = 1'b1;
                    end
                endcase
            end
            LP01: begin
                case (w_lp)
                    LP_01:   w_next_state = LP01;
                    LP_11:   w_next_state = LP11;
                    LP_00: begin
                        w_next_state = LP00;
                        w_settle_cnt = 4'd0;
                    end
                    default: begin
                        w_next_state = STOP_WAIT;
                        w_err_ctrl   = 1'b1;
                    end
                endcase
            end
            LP00: begin
                case (w_lp)
                    LP_00: begin
                        if (r_settle_cnt == SETTLE_LAST) begin
                            w_next_state = HS_SYNC;
                            w_sync_cnt   = 8'd0;
                        end else begin
                            w_settle_cnt = r_settle_cnt + 4'd1;
                        end
                    end
                    LP_11:   w_next_state = LP11;
                    default: begin
                        w_next_state = STOP_WAIT;
                        w_err_ctrl   = 1'b1;
                    end
                endcase
            end
            HS_SYNC: begin
                case (w_lp)
                    LP_00: begin
                        // A match on the timeout cycle still counts as sync found.
                        if (w_match) begin
                            w_next_state = HS_DATA;
                            w_sot        = 1'b1;
                        end else if (r_sync_cnt == SYNC_LAST) begin
                            w_next_state = STOP_WAIT;
                            w_err_sot    = 1'b1;
                        end else begin
                            w_sync_cnt = r_sync_cnt + 8'd1;
                        end
                    end
                    LP_11:   w_next_state = LP11;
                    default: begin
                        w_next_state = STOP_WAIT;
                        w_err_ctrl   = 1'b1;
                    end
                endcase
            end
            HS_DATA: begin
                case (w_lp)
                    LP_00: begin
                        w_valid = 1'b1;
                        w_data  = w_aligned;
                    end
                    LP_11: begin
                        w_next_state = LP11;
                        w_eot        = 1'b1;
                    end
                    default: begin
                        w_next_state = STOP_WAIT;
                        w_err_ctrl   = 1'b1;
                    end
                endcase
            end
            default: w_next_state = STOP_WAIT;
        endcase
    end

    assign w_latch      = (r_state == HS_SYNC) && (w_next_state == HS_DATA);
    assign w_hs_term_en = (w_next_state == LP00) || (w_next_state == HS_SYNC) ||
                          (w_next_state == HS_DATA);
    assign w_lane_idle  = (w_next_state == LP11);

    // State, counters and registered outputs.
    always_ff @(posedge byte_clk or posedge byte_rst) begin
        if (byte_rst) begin
            r_state      <= STOP_WAIT;
            r_settle_cnt <= 4'd0;
            r_sync_cnt   <= 8'd0;
            r_data       <= 8'h00;
            r_valid      <= 1'b0;
            r_sot        <= 1'b0;
            r_eot        <= 1'b0;
            r_err_sot    <= 1'b0;
            r_err_ctrl   <= 1'b0;
            r_hs_term_en <= 1'b0;
            r_lane_idle  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_settle_cnt <= w_settle_cnt;
            r_sync_cnt   <= w_sync_cnt;
            r_data       <= w_data;
            r_valid      <= w_valid;
            r_sot        <= w_sot;
            r_eot        <= w_eot;
            r_err_sot    <= w_err_sot;
            r_err_ctrl   <= w_err_ctrl;
            r_hs_term_en <= w_hs_term_en;
            r_lane_idle  <= w_lane_idle;
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign sot        = r_sot;
    assign eot        = r_eot;
    assign err_sot    = r_err_sot;
    assign err_ctrl   = r_err_ctrl;
    assign hs_term_en = r_hs_term_en;
    assign lane_idle  = r_lane_idle;

endmodule

// File: tb/tb_data_lane_rx.sv
// Directed bench for data_lane_rx; tolerant-sync expectations follow DATA_LANE_RX_SOT_TOLERANT_EN.
`timescale 1ns/1ps
module tb_data_lane_rx;

    logic       byte_clk = 1'b0;
    logic       byte_rst;
    logic       lp_p;
    logic       lp_n;
    logic [7:0] rx_byte;
    logic [7:0] data;
    logic       valid;
    logic       sot;
    logic       eot;
    logic       err_sot;
    logic       err_ctrl;
    logic       hs_term_en;
    logic       lane_idle;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] prev_b;

    data_lane_rx #(.TD_SETTLE(4), .SYNC_TIMEOUT(16)) dut (
        .byte_clk   (byte_clk),
        .byte_rst   (byte_rst),
        .lp_p       (lp_p),
        .lp_n       (lp_n),
        .rx_byte    (rx_byte),
        .data       (data),
        .valid      (valid),
        .sot        (sot),
        .eot        (eot),
        .err_sot    (err_sot),
        .err_ctrl   (err_ctrl),
        .hs_term_en (hs_term_en),
        .lane_idle  (lane_idle)
    );

    always #5 byte_clk = ~byte_clk;

    task automatic tick();
        @(posedge byte_clk);
        #1;
    endtask

    task automatic lp_step(input logic [1:0] v);
        {lp_p, lp_n} = v;
        repeat (3) tick();
    endtask

    task automatic feed(input logic [7:0] b);
        rx_byte = b;
        tick();
    endtask

    // From LP11: LP01, LP00, then settle until the sync search is running.
    task automatic enter_hs_sync();
        rx_byte = 8'h00;
        lp_step(2'b01);
        n_vec++; if (lane_idle !== 1'b0) begin n_err++; $display("FAIL lp01_idle: got %0b want 0", lane_idle); end
        lp_step(2'b00);
        n_vec++; if (hs_term_en !== 1'b1) begin n_err++; $display("FAIL lp00_term: got %0b want 1", hs_term_en); end
        repeat (4) tick();
        n_vec++; if (hs_term_en !== 1'b1 || sot !== 1'b0) begin n_err++; $display("FAIL settle_done: term=%0b sot=%0b want 1/0", hs_term_en, sot); end
    endtask

    task automatic test_reset();
        byte_rst = 1'b1;
        {lp_p, lp_n} = 2'b00;
        rx_byte = 8'h00;
        repeat (3) tick();
        n_vec++; if ({data, valid, sot, eot, err_sot, err_ctrl, hs_term_en, lane_idle} !== 15'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h want 0", {data, valid, sot, eot, err_sot, err_ctrl, hs_term_en, lane_idle});
        end
        byte_rst = 1'b0;
        repeat (2) tick();
        n_vec++; if (lane_idle !== 1'b0 || hs_term_en !== 1'b0) begin n_err++; $display("FAIL stop_wait_idle: idle=%0b term=%0b want 0/0", lane_idle, hs_term_en); end
    endtask

    task automatic test_sot_align();
        logic [39:0] v;
        v = (40'h34 << 19) | (40'h12 << 11) | (40'hB8 << 3);
        lp_step(2'b11);
        n_vec++; if (lane_idle !== 1'b1) begin n_err++; $display("FAIL lp11_idle: got %0b want 1", lane_idle); end
        enter_hs_sync();
        feed(v[7:0]);
        n_vec++; if (sot !== 1'b0) begin n_err++; $display("FAIL sot_early: got %0b want 0", sot); end
        feed(v[15:8]);
        n_vec++; if (sot !== 1'b1 || valid !== 1'b0) begin n_err++; $display("FAIL sot_pulse: sot=%0b valid=%0b want 1/0", sot, valid); end
        feed(v[23:16]);
        n_vec++; if (valid !== 1'b1 || data !== 8'h12 || sot !== 1'b0) begin n_err++; $display("FAIL first_byte: valid=%0b data=%h sot=%0b want 1/12/0", valid, data, sot); end
        feed(v[31:24]);
        n_vec++; if (valid !== 1'b1 || data !== 8'h34) begin n_err++; $display("FAIL second_byte: valid=%0b data=%h want 1/34", valid, data); end
        prev_b = v[31:24];
    endtask

    task automatic test_eot();
        logic [15:0] w;
        logic [7:0]  exp_b;
        {lp_p, lp_n} = 2'b11;
        w = {8'hA5, prev_b}; exp_b = w[10:3];
        feed(8'hA5);
        n_vec++; if (valid !== 1'b1 || data !== exp_b || eot !== 1'b0) begin n_err++; $display("FAIL trailer_a5: valid=%0b data=%h eot=%0b want 1/%h/0", valid, data, eot, exp_b); end
        w = {8'h3C, 8'hA5}; exp_b = w[10:3];
        feed(8'h3C);
        n_vec++; if (valid !== 1'b1 || data !== exp_b) begin n_err++; $display("FAIL trailer_3c: valid=%0b data=%h want 1/%h", valid, data, exp_b); end
        feed(8'h0F);
        n_vec++; if (eot !== 1'b1 || valid !== 1'b0 || lane_idle !== 1'b1) begin n_err++; $display("FAIL eot_pulse: eot=%0b valid=%0b idle=%0b want 1/0/1", eot, valid, lane_idle); end
        feed(8'h00);
        n_vec++; if (eot !== 1'b0 || lane_idle !== 1'b1 || hs_term_en !== 1'b0) begin n_err++; $display("FAIL eot_after: eot=%0b idle=%0b term=%0b want 0/1/0", eot, lane_idle, hs_term_en); end
    endtask

    task automatic test_timeout();
        enter_hs_sync();
        repeat (15) feed(8'h00);
        n_vec++; if (err_sot !== 1'b0 || hs_term_en !== 1'b1) begin n_err++; $display("FAIL timeout_early: err_sot=%0b term=%0b want 0/1", err_sot, hs_term_en); end
        feed(8'h00);
        n_vec++; if (err_sot !== 1'b1 || hs_term_en !== 1'b0 || lane_idle !== 1'b0 || sot !== 1'b0) begin
            n_err++; $display("FAIL timeout_hit: err_sot=%0b term=%0b idle=%0b sot=%0b want 1/0/0/0", err_sot, hs_term_en, lane_idle, sot);
        end
        feed(8'h00);
        n_vec++; if (err_sot !== 1'b0) begin n_err++; $display("FAIL timeout_pulse_width: got %0b want 0", err_sot); end
    endtask

    task automatic test_ctrl_err();
        lp_step(2'b11);
        n_vec++; if (lane_idle !== 1'b1) begin n_err++; $display("FAIL ctrl_lp11: got %0b want 1", lane_idle); end
        lp_step(2'b10);
        n_vec++; if (err_ctrl !== 1'b1 || hs_term_en !== 1'b0 || lane_idle !== 1'b0) begin n_err++; $display("FAIL ctrl_err_10: err=%0b term=%0b idle=%0b want 1/0/0", err_ctrl, hs_term_en, lane_idle); end
        tick();
        n_vec++; if (err_ctrl !== 1'b0) begin n_err++; $display("FAIL ctrl_err_width: got %0b want 0", err_ctrl); end
        lp_step(2'b11);
        lp_step(2'b01);
        n_vec++; if (err_ctrl !== 1'b0 || lane_idle !== 1'b0) begin n_err++; $display("FAIL ctrl_lp01: err=%0b idle=%0b want 0/0", err_ctrl, lane_idle); end
        lp_step(2'b11);
        n_vec++; if (err_ctrl !== 1'b0 || lane_idle !== 1'b1) begin n_err++; $display("FAIL ctrl_back_lp11: err=%0b idle=%0b want 0/1", err_ctrl, lane_idle); end
    endtask

    task automatic test_reset_mid_hs();
        logic [39:0] v;
        logic        seen_eot;
        v = (40'h34 << 19) | (40'h12 << 11) | (40'hB8 << 3);
        enter_hs_sync();
        feed(v[7:0]);
        feed(v[15:8]);
        feed(v[23:16]);
        n_vec++; if (valid !== 1'b1 || data !== 8'h12) begin n_err++; $display("FAIL pre_reset_data: valid=%0b data=%h want 1/12", valid, data); end
        rx_byte = v[31:24];
        #2 byte_rst = 1'b1;
        #1;
        n_vec++; if ({data, valid, sot, eot, err_sot, err_ctrl, hs_term_en, lane_idle} !== 15'd0) begin
            n_err++; $display("FAIL async_reset: got %h want 0", {data, valid, sot, eot, err_sot, err_ctrl, hs_term_en, lane_idle});
        end
        tick();
        byte_rst = 1'b0;
        seen_eot = 1'b0;
        for (int i = 0; i < 6; i++) begin
            feed(8'hB8);
            seen_eot = seen_eot | eot;
        end
        n_vec++; if (seen_eot !== 1'b0 || hs_term_en !== 1'b0 || valid !== 1'b0 || lane_idle !== 1'b0) begin
            n_err++; $display("FAIL post_reset_quiet: eot=%0b term=%0b valid=%0b idle=%0b want 0/0/0/0", seen_eot, hs_term_en, valid, lane_idle);
        end
        rx_byte = 8'h00;
        lp_step(2'b11);
        n_vec++; if (lane_idle !== 1'b1) begin n_err++; $display("FAIL resume_lp11: got %0b want 1", lane_idle); end
    endtask

    task automatic test_tolerant();
        logic [39:0] v;
        v = (40'h5A << 11) | (40'hB9 << 3);
        enter_hs_sync();
        feed(v[7:0]);
        n_vec++; if (sot !== 1'b0) begin n_err++; $display("FAIL tol_early: got %0b want 0", sot); end
        feed(v[15:8]);
`ifdef DATA_LANE_RX_SOT_TOLERANT_EN
        n_vec++; if (sot !== 1'b1) begin n_err++; $display("FAIL tol_sot: got %0b want 1", sot); end
        feed(v[23:16]);
        n_vec++; if (valid !== 1'b1 || data !== 8'h5A) begin n_err++; $display("FAIL tol_data: valid=%0b data=%h want 1/5a", valid, data); end
`else
        n_vec++; if (sot !== 1'b0) begin n_err++; $display("FAIL exact_no_sot: got %0b want 0", sot); end
        feed(v[23:16]);
        repeat (12) feed(8'h00);
        n_vec++; if (err_sot !== 1'b0 || valid !== 1'b0) begin n_err++; $display("FAIL exact_wait: err_sot=%0b valid=%0b want 0/0", err_sot, valid); end
        feed(8'h00);
        n_vec++; if (err_sot !== 1'b1) begin n_err++; $display("FAIL exact_err_sot: got %0b want 1", err_sot); end
`endif
    endtask

    initial begin
        test_reset();
        test_sot_align();
        test_eot();
        test_timeout();
        test_ctrl_err();
        test_reset_mid_hs();
        test_tolerant();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_lane_rx.md
DATA_LANE_RX -- requirements
Module: data_lane_rx

Interface
REQ-001 TD_SETTLE, 4: byte_clk cycles spent in LP00 before sync search starts (range 1..15).
REQ-002 SYNC_TIMEOUT, 16: max HS_SYNC cycles without a sync match (range 1..255).
REQ-003 byte_clk  in  1  byte clock; the only clock.
REQ-004 byte_rst  in  1  asynchronous, active-high reset.
REQ-005 lp_p, lp_n  in  1 each  raw LP receiver outputs, asynchronous to byte_clk.
REQ-006 rx_byte  in  8  raw deserializer byte, new every cycle, bit 0 received first, unaligned.
REQ-007 data  out  8  aligned HS payload byte.
REQ-008 valid  out  1  data is valid this cycle.
REQ-009 sot, eot  out  1 each  one-cycle pulses: sync found / LP11 seen after HS.
REQ-010 err_sot  out  1  one-cycle pulse: sync timeout.
REQ-011 err_ctrl  out  1  one-cycle pulse: illegal LP sequence.
REQ-012 hs_term_en  out  1  enables HS termination/deserializer.
REQ-013 lane_idle  out  1  lane in LP11 stop state.

Function
REQ-014 lp_p/lp_n SHALL pass through a 2-flop synchronizer; "LP" below means the synchronized pair {lp_p, lp_n}.
REQ-015 States SHALL be STOP_WAIT, LP11, LP01, LP00, HS_SYNC, HS_DATA; reset enters STOP_WAIT.
REQ-016 STOP_WAIT -> LP11 when LP=11; other values stay, no error.
REQ-017 LP11 -> LP01 on LP=01; LP=10 or 00 -> STOP_WAIT with err_ctrl.
REQ-018 LP01 -> LP00 on LP=00; LP=11 -> LP11 silently; LP=10 -> STOP_WAIT with err_ctrl.
REQ-019 LP00: 4-bit counter cleared on entry; -> HS_SYNC when count reaches TD_SETTLE-1; any LP other than 00 -> STOP_WAIT (err_ctrl unless LP=11, then LP11).
REQ-020 HS_SYNC: 16-bit window {rx_byte, prev rx_byte}; offset k (0..7) matches when window[k+7:k]=8'hB8; lowest matching k wins and is latched; -> HS_DATA with sot pulse.
REQ-021 HS_SYNC: 8-bit counter; when SYNC_TIMEOUT cycles elapse with no match -> STOP_WAIT with err_sot.
REQ-022 HS_DATA: data = window[k+7:k] registered, valid=1 every cycle, first valid byte = byte following sync, latency one cycle after its last bit arrives in rx_byte.
REQ-023 HS_DATA/HS_SYNC: LP=11 -> LP11, eot pulse (HS_DATA only), valid=0 same cycle; LP=01 or 10 -> STOP_WAIT with err_ctrl.
REQ-024 EoT trailer bytes SHALL be forwarded unmodified; packet-length stripping belongs to the protocol layer.
REQ-025 hs_term_en=1 in LP00, HS_SYNC, HS_DATA; lane_idle=1 only in LP11.
REQ-026 Simultaneous sync match and timeout: match wins.

Reset
REQ-027 On byte_rst: data=0, valid=0, all pulses 0, hs_term_en=0, lane_idle=0, counters and synchronizer flops 0, offset 0, state STOP_WAIT; assertion mid-HS aborts with no eot.

Configuration
REQ-028 DATA_LANE_RX_SOT_TOLERANT_EN defined: HS_SYNC also accepts a window slice differing from 8'hB8 in exactly one bit, only when no exact match exists at any offset; sot pulses as normal.
REQ-029 Macro undefined: exact match only; port list identical in both builds.

Structure
REQ-030 Package data_lane_rx_pkg SHALL hold the state enum, SYNC_BYTE=8'hB8 and LP code constants (LP_11, LP_01, LP_00, LP_10).
REQ-031 Sub-module data_rx_align SHALL contain window, offset search (incl. tolerant match) and aligned-byte mux; the FSM stays in data_lane_rx.

Verification
REQ-032 LP 11->01->00, after TD_SETTLE rx_byte stream with B8 at offset 3 then 0x12,0x34 -> sot, data 0x12,0x34 valid, k=3.
REQ-033 HS burst then LP=11 -> eot one cycle, valid drops, lane_idle=1 two cycles later.
REQ-034 LP00 then 16 cycles of 0x00 -> err_sot, state STOP_WAIT, hs_term_en=0.
REQ-035 LP 11->10 -> err_ctrl, no hs_term_en; LP 11->01->11 -> no error, back to LP11.
REQ-036 Sync 0xB9 (one-bit error): with macro -> sot and aligned data; without -> err_sot.
REQ-037 byte_rst asserted mid HS_DATA -> all outputs 0 immediately, no eot, resumes only after LP11.
